blk_9b4ae0: RTL and testbench
=============================

# error_module_parameter_delay_not_set_correctly_in_gf_inv

Runtime latency checker bound beside a GF(3) inverse pipeline (GFE_inv-style, two-lane, registered lookup). It verifies that the pipeline's output-valid strobe follows its input-valid strobe by exactly the configured DELAY cycles. It also flags an illegal DELAY setting, and reports sticky error status plus a mismatch count. It has no datapath effect; it only observes.

## Interface
- DELAY, default 1: required input-to-output latency in cycles; legal range 1..MAX_DELAY.
- MAX_DELAY, default 15: depth of the expectation shift register; upper bound for DELAY.
- clk  in  1  rising-edge clock, shared with the monitored pipeline.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- in_valid  in  1  pipeline accepted an operand this cycle.
- out_valid  in  1  pipeline presented a result this cycle.
- err  out  1  sticky error flag.
- err_code  out  2  sticky first-error code: 00 none, 01 missing/late result, 10 spurious/early result, 11 illegal DELAY.
- err_cnt  out  8  saturating count of mismatch cycles.
- measured_delay  out  4  cycles from first in_valid to first out_valid after reset.
- measure_done  out  1  measured_delay is valid.

## Operation
- Parameter legality: DELAY < 1 or DELAY > MAX_DELAY is illegal. Illegal DELAY sets err=1 and err_code=11 on the first clock after reset release. In that state the runtime checks are disabled and err_cnt stays 0.
- Expectation pipe: MAX_DELAY-bit shift register, bit 0 loaded with in_valid each cycle. The expected strobe exp = bit DELAY-1, i.e. in_valid delayed by DELAY cycles.
- Each cycle, compare exp with out_valid:
  - exp=1, out_valid=0: missing. Code 01.
  - exp=0, out_valid=1: spurious. Code 10.
  - On either mismatch, err_cnt increments and saturates at 255.
- Fully pipelined: in_valid may be asserted every cycle. Each token is checked independently and no ordering is tracked.
- err_code records only the first error after reset; later errors never overwrite it. err stays 1 until reset.
- If missing and spurious could both apply in one cycle, the result is one mismatch, counted once.
- Measurement: a counter starts on the first in_valid after reset. It increments each cycle until the first out_valid, then freezes and sets measure_done=1.
  - out_valid in the same cycle as the first in_valid gives 0.
  - The counter saturates at 15 with measure_done=0 if no out_valid arrives.

## Timing
- Reset values: err=0, err_code=00, err_cnt=0, measured_delay=0, measure_done=0, shift register cleared.
- Reset mid-stream: tokens in flight are discarded. A result arriving after reset release with no post-reset in_valid is flagged spurious.
- Status outputs are registered. A mismatch in cycle t shows on err/err_code/err_cnt after the clock edge ending cycle t.
- measure_done rises on the edge that captures the first out_valid.
- in_valid during reset assertion is ignored.

## Configuration
- GF_INV_DELAY_CHK_MEASURE_EN:
  - Defined: the measurement counter, measured_delay and measure_done are built.
  - Undefined: measured_delay is tied to 0 and measure_done to 0; the checking logic is unchanged.

## Test plan
- DELAY=1; in_valid pulse at cycle 3, out_valid at cycle 4 -> err=0, err_cnt=0, measured_delay=1, measure_done=1.
- DELAY=1; in_valid every cycle for 8 cycles, out_valid one cycle later for 8 cycles -> no error.
- DELAY=1; in_valid at 3, out_valid at 5 -> missing at 4 (err_code=01), spurious at 5, err_cnt=2, err_code stays 01, measured_delay=2.
- DELAY=1; out_valid with no prior in_valid -> err=1, err_code=10, err_cnt=1.
- DELAY=0 (or 16) -> err=1, err_code=11 one cycle after reset release; err_cnt=0 regardless of stimulus.
- Errors present, then rst_n=0 for one cycle -> all outputs return to reset values; a subsequent correct stream gives no error.

Source files
------------

// File: rtl/blk_9b4ae0.sv
// Latency checker for a two-lane GF(3) inverse pipeline: out_valid must equal in_valid delayed by DELAY.
// Define GF_INV_DELAY_CHK_MEASURE_EN to build the first-token latency measurement counter.
module blk_9b4ae0 #(
    parameter int DELAY     = 1,
    parameter int MAX_DELAY = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       out_valid,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] err_cnt,
    output logic [3:0] measured_delay,
    output logic       measure_done
);
    localparam bit DELAY_OK = (DELAY >= 1) && (DELAY <= MAX_DELAY);
    // An illegal DELAY still needs an in-range tap so the design elaborates.
    localparam int EXP_IDX  = DELAY_OK ? (DELAY - 1) : 0;

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_MISSING  = 2'b01;
    localparam logic [1:0] CODE_SPURIOUS = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL  = 2'b11;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    logic [MAX_DELAY-1:0] exp_pipe_r;
    logic                 err_r;
    logic [1:0]           err_code_r;
    logic [7:0]           err_cnt_r;

    logic                 exp_s;
    logic                 missing_s;
    logic                 spurious_s;
    logic                 err_nxt_s;
    logic [1:0]           err_code_nxt_s;
    logic [7:0]           err_cnt_nxt_s;

    // Compare the delayed expectation with out_valid and build the next sticky status.
    always_comb begin
        exp_s          = exp_pipe_r[EXP_IDX];
        missing_s      = exp_s & ~out_valid;
        spurious_s     = ~exp_s & out_valid;
        err_nxt_s      = err_r;
        err_code_nxt_s = err_code_r;
        err_cnt_nxt_s  = err_cnt_r;
        if (!DELAY_OK) begin
            err_nxt_s = 1'b1;
            if (err_code_r == CODE_NONE) begin
                err_code_nxt_s = CODE_ILLEGAL;
            end else begin
                err_code_nxt_s = err_code_r;
            end
        end else if (missing_s || spurious_s) begin
            err_nxt_s     = 1'b1;
            err_cnt_nxt_s = sat_inc8(err_cnt_r);
            if (err_code_r != CODE_NONE) begin
                err_code_nxt_s = err_code_r;
            end else if (missing_s) begin
                err_code_nxt_s = CODE_MISSING;
            end else begin
                err_code_nxt_s = CODE_SPURIOUS;
            end
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Expectation shift register and registered status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_pipe_r <= '0;
            err_r      <= 1'b0;
            err_code_r <= CODE_NONE;
            err_cnt_r  <= 8'd0;
        end else begin
            exp_pipe_r <= {exp_pipe_r[MAX_DELAY-2:0], in_valid};
            err_r      <= err_nxt_s;
            err_code_r <= err_code_nxt_s;
            err_cnt_r  <= err_cnt_nxt_s;
        end
    end

    assign err      = err_r;
    assign err_code = err_code_r;
    assign err_cnt  = err_cnt_r;

`ifdef GF_INV_DELAY_CHK_MEASURE_EN
    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_RUN  = 2'd1,
        M_DONE = 2'd2
    } meas_state_t;

    meas_state_t meas_state_r;
    meas_state_t meas_state_nxt_s;
    logic [3:0]  meas_cnt_r;
    logic [3:0]  meas_cnt_nxt_s;
    logic        meas_done_r;

    // Measurement FSM: wait for the first in_valid, count until the first out_valid, then freeze.
    always_comb begin
        meas_state_nxt_s = meas_state_r;
        meas_cnt_nxt_s   = meas_cnt_r;
        case (meas_state_r)
            M_IDLE: begin
                if (in_valid && out_valid) begin
                    meas_state_nxt_s = M_DONE;
                    meas_cnt_nxt_s   = 4'd0;
                end else if (in_valid) begin
                    meas_state_nxt_s = M_RUN;
                    meas_cnt_nxt_s   = 4'd1;
                end else begin
                    meas_state_nxt_s = M_IDLE;
                end
            end
            M_RUN: begin
                if (out_valid) begin
                    meas_state_nxt_s = M_DONE;
                end else if (meas_cnt_r != 4'd15) begin
                    meas_cnt_nxt_s = meas_cnt_r + 4'd1;
                end else begin
                    meas_cnt_nxt_s = meas_cnt_r;
                end
            end
            M_DONE: begin
                meas_state_nxt_s = M_DONE;
            end
            default: begin
                meas_state_nxt_s = M_IDLE;
                meas_cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Measurement state, count and done flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meas_state_r <= M_IDLE;
            meas_cnt_r   <= 4'd0;
            meas_done_r  <= 1'b0;
        end else begin
            meas_state_r <= meas_state_nxt_s;
            meas_cnt_r   <= meas_cnt_nxt_s;
            meas_done_r  <= (meas_state_nxt_s == M_DONE);
        end
    end

    assign measured_delay = meas_cnt_r;
    assign measure_done   = meas_done_r;
`else
    assign measured_delay = 4'd0;
    assign measure_done   = 1'b0;
`endif

endmodule

// File: tb/tb_blk_9b4ae0.sv
// Bench for blk_9b4ae0: four instances (DELAY 1, 3, 0, 16) against a history-based reference model.
module tb_blk_9b4ae0;
    logic clk = 1'b0;
    logic rst_n, iv, ov1, ov3;
    logic [3:0]      d_err;
    logic [3:0][1:0] d_code;
    logic [3:0][7:0] d_cnt;
    logic [3:0][3:0] d_md;
    logic [3:0]      d_done;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    blk_9b4ae0 #(.DELAY(1))  u_d1  (.clk(clk), .rst_n(rst_n), .in_valid(iv), .out_valid(ov1),
        .err(d_err[0]), .err_code(d_code[0]), .err_cnt(d_cnt[0]), .measured_delay(d_md[0]), .measure_done(d_done[0]));
    blk_9b4ae0 #(.DELAY(3))  u_d3  (.clk(clk), .rst_n(rst_n), .in_valid(iv), .out_valid(ov3),
        .err(d_err[1]), .err_code(d_code[1]), .err_cnt(d_cnt[1]), .measured_delay(d_md[1]), .measure_done(d_done[1]));
    blk_9b4ae0 #(.DELAY(0))  u_d0  (.clk(clk), .rst_n(rst_n), .in_valid(iv), .out_valid(ov1),
        .err(d_err[2]), .err_code(d_code[2]), .err_cnt(d_cnt[2]), .measured_delay(d_md[2]), .measure_done(d_done[2]));
    blk_9b4ae0 #(.DELAY(16)) u_d16 (.clk(clk), .rst_n(rst_n), .in_valid(iv), .out_valid(ov1),
        .err(d_err[3]), .err_code(d_code[3]), .err_cnt(d_cnt[3]), .measured_delay(d_md[3]), .measure_done(d_done[3]));

    // Reference model: full in_valid history since reset release, sticky status per instance.
    int dly [4] = '{1, 3, 0, 16};
    bit hist[$];
    bit m_err [4];
    int m_code [4];
    int m_cnt [4];
    int first_out [4];
    int first_in;
    int idx;
    bit m_ov, m_ex;

    task automatic check(input string nm, input int k, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s inst%0d got %0d expected %0d at %0t", nm, k, act, exp, $time);
    endtask

    // Model update on the same edge the DUT samples.
    always @(posedge clk) begin
        if (!rst_n) begin
            hist.delete();
            first_in = -1;
            for (int k = 0; k < 4; k++) begin
                m_err[k] = 1'b0; m_code[k] = 0; m_cnt[k] = 0; first_out[k] = -1;
            end
        end else begin
            idx = hist.size();
            hist.push_back(iv);
            if (first_in < 0 && iv) first_in = idx;
            for (int k = 0; k < 4; k++) begin
                m_ov = (k == 1) ? ov3 : ov1;
                if (dly[k] < 1 || dly[k] > 15) begin
                    m_err[k] = 1'b1;
                    if (m_code[k] == 0) m_code[k] = 3;
                end else begin
                    m_ex = (idx >= dly[k]) ? hist[idx - dly[k]] : 1'b0;
                    if (m_ex != m_ov) begin
                        m_err[k] = 1'b1;
                        if (m_cnt[k] < 255) m_cnt[k]++;
                        if (m_code[k] == 0) m_code[k] = m_ex ? 1 : 2;
                    end
                end
                if (first_in >= 0 && first_out[k] < 0 && m_ov) first_out[k] = idx;
            end
        end
    end

    function automatic int exp_md(input int k);
`ifdef GF_INV_DELAY_CHK_MEASURE_EN
        int v;
        if (first_in < 0) return 0;
        v = (first_out[k] >= 0) ? (first_out[k] - first_in) : (hist.size() - first_in);
        return (v > 15) ? 15 : v;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_done(input int k);
`ifdef GF_INV_DELAY_CHK_MEASURE_EN
        return (first_out[k] >= 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                check("err", k, int'(d_err[k]), int'(m_err[k]));
                check("err_code", k, int'(d_code[k]), m_code[k]);
                check("err_cnt", k, int'(d_cnt[k]), m_cnt[k]);
                check("measured_delay", k, int'(d_md[k]), exp_md(k));
                check("measure_done", k, int'(d_done[k]), exp_done(k));
            end
        end
    end

    task automatic do_reset(input bit iv_during);
        rst_n = 1'b0; iv = iv_during; ov1 = 1'b0; ov3 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; iv = 1'b0;
    endtask

    // Bit t of each pattern drives cycle t after reset release.
    task automatic run(input logic [63:0] ivp, input logic [63:0] o1p, input logic [63:0] o3p, input int n);
        for (int t = 0; t < n; t++) begin
            iv = ivp[t]; ov1 = o1p[t]; ov3 = o3p[t];
            @(posedge clk); #1;
        end
        iv = 1'b0; ov1 = 1'b0; ov3 = 1'b0;
    endtask

    int md_lit;
    bit h1, h2, h3;

    initial begin
        rst_n = 1'b0; iv = 1'b0; ov1 = 1'b0; ov3 = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("lit_reset_err", 2, int'(d_err[2]), 0);
        check("lit_reset_code", 2, int'(d_code[2]), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("lit_illegal_code", 2, int'(d_code[2]), 3);
        check("lit_illegal_code", 3, int'(d_code[3]), 3);
        check("lit_illegal_err", 3, int'(d_err[3]), 1);

        // Single token, correct latency on both legal instances.
        do_reset(1'b1);
        run(64'h1 << 3, 64'h1 << 4, 64'h1 << 6, 10);
`ifdef GF_INV_DELAY_CHK_MEASURE_EN
        md_lit = 1;
`else
        md_lit = 0;
`endif
        check("lit_single_err", 0, int'(d_err[0]), 0);
        check("lit_single_cnt", 0, int'(d_cnt[0]), 0);
        check("lit_single_md", 0, int'(d_md[0]), md_lit);
        check("lit_single_err", 1, int'(d_err[1]), 0);

        // Back-to-back burst of eight.
        do_reset(1'b0);
        run(64'hFF << 2, 64'hFF << 3, 64'hFF << 5, 16);
        check("lit_burst_err", 0, int'(d_err[0]), 0);
        check("lit_burst_err", 1, int'(d_err[1]), 0);
        check("lit_burst_illegal_cnt", 2, int'(d_cnt[2]), 0);

        // Late result: missing then spurious.
        do_reset(1'b0);
        run(64'h1 << 3, 64'h1 << 5, 64'h1 << 6, 8);
        check("lit_late_cnt", 0, int'(d_cnt[0]), 2);
        check("lit_late_code", 0, int'(d_code[0]), 1);
        check("model_late_cnt", 0, m_cnt[0], 2);
        check("model_late_code", 0, m_code[0], 1);
`ifdef GF_INV_DELAY_CHK_MEASURE_EN
        check("lit_late_md", 0, int'(d_md[0]), 2);
`endif

        // Result with no token.
        do_reset(1'b0);
        run(64'h0, 64'h1 << 2, 64'h0, 5);
        check("lit_spur_code", 0, int'(d_code[0]), 2);
        check("lit_spur_cnt", 0, int'(d_cnt[0]), 1);
        check("model_spur_code", 0, m_code[0], 2);

        // Token in flight across a reset becomes spurious afterwards; then a clean stream.
        do_reset(1'b0);
        run(64'h1 << 5, 64'h0, 64'h0, 6);
        do_reset(1'b0);
        run(64'h0, 64'h1, 64'h0, 3);
        check("lit_flight_code", 0, int'(d_code[0]), 2);
        do_reset(1'b0);
        run(64'h5 << 1, 64'h5 << 2, 64'h5 << 4, 10);
        check("lit_clean_err", 0, int'(d_err[0]), 0);
        check("lit_clean_err", 1, int'(d_err[1]), 0);

        // Randomized streams: mostly correct latency, rare corruption, rare resets.
        do_reset(1'b0);
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
                h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
            end else begin
                iv  = ($urandom_range(0, 2) != 0);
                ov1 = h1 ^ ($urandom_range(0, 39) == 0);
                ov3 = h3 ^ ($urandom_range(0, 39) == 0);
                h3 = h2; h2 = h1; h1 = iv;
                @(posedge clk); #1;
            end
        end
        iv = 1'b0; ov1 = 1'b0; ov3 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
